// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the divider issue controller: op codes and FSM state encoding.
package div_ctrl_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b10,
        ST_DRAIN  = 2'b11
    } state_t;

    // DIV and DIVU share a clear msb; MTHI/MTLO have it set.
    function automatic logic is_div_op(input logic [1:0] code);
        return ~code[1];
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO registers with independent write enables and the MFHI/MFLO read mux,
// which can forward a result arriving in the same cycle.
module hilo_regs #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              hi_we,
    input  logic [DATA_W-1:0] hi_wdata,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] lo_wdata,
    input  logic              fwd_en,
    input  logic [DATA_W-1:0] fwd_hi,
    input  logic [DATA_W-1:0] fwd_lo,
    input  logic              mf_sel,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] mf_data
);

    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else begin
            if (hi_we) hi_reg <= hi_wdata;
            if (lo_we) lo_reg <= lo_wdata;
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;

    always_comb begin
        if (fwd_en) mf_data = mf_sel ? fwd_hi : fwd_lo;
        else        mf_data = mf_sel ? hi_reg : lo_reg;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU ops to the shared iterative divider, owns HI/LO, stalls MF readers while a
// result is pending and drains divides cancelled by a pipeline flush.
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DIV_TIMEOUT = 48
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] op_rs,
    input  logic [DATA_W-1:0] op_rt,
    input  logic              flush,
    input  logic              mf_valid,
    input  logic              mf_sel,
    output logic [DATA_W-1:0] mf_data,
    output logic              mf_stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              err,
    output logic              div_en,
    output logic              div_signed,
    output logic [DATA_W-1:0] div_dividend,
    output logic [DATA_W-1:0] div_divisor,
    input  logic              div_busy,
    input  logic              div_complete,
    input  logic [DATA_W-1:0] div_quotient,
    input  logic [DATA_W-1:0] div_remainder
);

    localparam int CNT_W = $clog2(DIV_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              err_reg, err_next;
    logic              signed_reg;
    logic [DATA_W-1:0] dividend_reg, divisor_reg;
    logic              latch_ops;
    logic              accept;
    logic              hi_we, lo_we;
    logic [DATA_W-1:0] hi_wdata, lo_wdata;
    logic              result_fwd;

    // The busy flag is informational only; completion is signalled by div_complete.
    logic unused_busy;
    assign unused_busy = div_busy;

    assign op_ready   = resetn & (state_reg == ST_IDLE) & ~flush;
    assign accept     = op_valid & op_ready;
    assign div_en     = (state_reg == ST_LAUNCH) & ~flush;
    assign result_fwd = (state_reg == ST_WAIT) & div_complete;
    assign mf_stall   = mf_valid & ((state_reg == ST_LAUNCH) |
                                    ((state_reg == ST_WAIT) & ~div_complete));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        latch_ops  = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hi_wdata   = op_rs;
        lo_wdata   = op_rs;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (is_div_op(op_code)) begin
                        // A zero divisor leaves HI/LO untouched and never reaches the divider.
                        if (op_rt != '0) begin
                            latch_ops  = 1'b1;
                            state_next = ST_LAUNCH;
                        end
                    end else if (op_code == OP_MTHI) begin
                        hi_we = 1'b1;
                    end else begin
                        lo_we = 1'b1;
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_next   = '0;
                state_next = flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                hi_wdata = div_remainder;
                lo_wdata = div_quotient;
                if (div_complete) begin
                    hi_we      = 1'b1;
                    lo_we      = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_next = cnt_reg + 1'b1;
                if (div_complete) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // Operands stay frozen from launch until the divider completes or is drained.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            signed_reg   <= 1'b0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
        end else if (latch_ops) begin
            signed_reg   <= (op_code == OP_DIV);
            dividend_reg <= op_rs;
            divisor_reg  <= op_rt;
        end
    end

    assign err          = err_reg;
    assign div_signed   = signed_reg;
    assign div_dividend = dividend_reg;
    assign div_divisor  = divisor_reg;

    hilo_regs #(.DATA_W(DATA_W)) u_hilo (
        .clk      (clk),
        .resetn   (resetn),
        .hi_we    (hi_we),
        .hi_wdata (hi_wdata),
        .lo_we    (lo_we),
        .lo_wdata (lo_wdata),
        .fwd_en   (result_fwd),
        .fwd_hi   (div_remainder),
        .fwd_lo   (div_quotient),
        .mf_sel   (mf_sel),
        .hi       (hi),
        .lo       (lo),
        .mf_data  (mf_data)
    );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: the bench plays the divider and scoreboards expected HI/LO.
module tb_div_issue_ctrl;
    import div_ctrl_pkg::*;

    localparam int DW  = 32;
    localparam int TMO = 48;

    logic          clk = 1'b0;
    logic          resetn;
    logic          op_valid, op_ready;
    logic [1:0]    op_code;
    logic [DW-1:0] op_rs, op_rt;
    logic          flush, mf_valid, mf_sel, mf_stall;
    logic [DW-1:0] mf_data, hi, lo;
    logic          err, div_en, div_signed;
    logic [DW-1:0] div_dividend, div_divisor;
    logic          div_busy, div_complete;
    logic [DW-1:0] div_quotient, div_remainder;

    always #5 clk = ~clk;

    div_issue_ctrl #(.DATA_W(DW), .DIV_TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_rs(op_rs), .op_rt(op_rt), .flush(flush),
        .mf_valid(mf_valid), .mf_sel(mf_sel), .mf_data(mf_data), .mf_stall(mf_stall),
        .hi(hi), .lo(lo), .err(err),
        .div_en(div_en), .div_signed(div_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_busy(div_busy), .div_complete(div_complete),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    typedef struct {
        logic [DW-1:0] quo;
        logic [DW-1:0] rem;
        logic [DW-1:0] exp_hi;
        logic [DW-1:0] exp_lo;
    } sb_t;

    sb_t           sb[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    logic [DW-1:0] hi_m, lo_m;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] code, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
        @(negedge clk);
        op_valid = 1'b1; op_code = code; op_rs = rs; op_rt = rt;
        #1 chk("op_ready_at_issue", {31'b0, op_ready}, 1);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Push the architecturally expected outcome of a divide that will complete normally.
    task automatic push_div(input logic sgn, input logic [DW-1:0] rs, input logic [DW-1:0] rt);
        sb_t e;
        if (sgn) begin
            e.quo = DW'($signed(rs) / $signed(rt));
            e.rem = DW'($signed(rs) % $signed(rt));
        end else begin
            e.quo = rs / rt;
            e.rem = rs % rt;
        end
        e.exp_hi = e.rem;
        e.exp_lo = e.quo;
        hi_m = e.rem;
        lo_m = e.quo;
        sb.push_back(e);
    endtask

    // Full divide: issue, check launch/stall behaviour, complete after lat WAIT cycles.
    task automatic do_div(input logic sgn, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                          input int lat, input logic rd_sel);
        sb_t e;
        push_div(sgn, rs, rt);
        issue(sgn ? OP_DIV : OP_DIVU, rs, rt);
        mf_valid = 1'b1; mf_sel = rd_sel;
        #1;
        chk("div_en_launch", {31'b0, div_en}, 1);
        chk("div_signed", {31'b0, div_signed}, {31'b0, sgn});
        chk("div_dividend", div_dividend, rs);
        chk("div_divisor", div_divisor, rt);
        chk("stall_launch", {31'b0, mf_stall}, 1);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk); #1;
            chk("div_en_wait", {31'b0, div_en}, 0);
            chk("stall_wait", {31'b0, mf_stall}, 1);
        end
        @(negedge clk);
        e = sb.pop_front();
        div_complete = 1'b1; div_quotient = e.quo; div_remainder = e.rem;
        #1;
        chk("stall_complete", {31'b0, mf_stall}, 0);
        chk("mf_fwd", mf_data, rd_sel ? e.exp_hi : e.exp_lo);
        @(negedge clk);
        div_complete = 1'b0; mf_valid = 1'b0;
        #1;
        chk("hi_after", hi, e.exp_hi);
        chk("lo_after", lo, e.exp_lo);
        chk("ready_after", {31'b0, op_ready}, 1);
    endtask

    initial begin
        int k;
        sb_t e;
        resetn = 1'b0; op_valid = 1'b0; op_code = 2'b00; op_rs = '0; op_rt = '0;
        flush = 1'b0; mf_valid = 1'b0; mf_sel = 1'b0; div_busy = 1'b0;
        div_complete = 1'b0; div_quotient = '0; div_remainder = '0;
        hi_m = '0; lo_m = '0;

        // Reset values
        #12;
        chk("rst_op_ready", {31'b0, op_ready}, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_div_en", {31'b0, div_en}, 0);
        chk("rst_dividend", div_dividend, 0);
        @(negedge clk); resetn = 1'b1;
        #1 chk("ready_idle", {31'b0, op_ready}, 1);
        $display("step reset: checked");

        // 1: signed divide, read HI in completion cycle
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 4, 1'b1);
        $display("step DIV -7/2: hi=%h lo=%h", hi, lo);

        // 2: unsigned divide, MFLO in completion cycle
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 6, 1'b0);
        $display("step DIVU: hi=%h lo=%h", hi, lo);

        // 3: MTHI, then divide by zero
        issue(OP_MTHI, 32'h1234, 32'h0);
        hi_m = 32'h1234;
        #1;
        chk("mthi_hi", hi, hi_m);
        chk("mthi_ready", {31'b0, op_ready}, 1);
        issue(OP_DIV, 32'd100, 32'd0);
        #1;
        chk("div0_no_en", {31'b0, div_en}, 0);
        chk("div0_ready", {31'b0, op_ready}, 1);
        chk("div0_hi", hi, hi_m);
        chk("div0_lo", lo, lo_m);
        $display("step MTHI/div0: hi=%h lo=%h", hi, lo);

        // Flush beats op_valid in IDLE
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MTLO; op_rs = 32'hDEAD; flush = 1'b1;
        #1 chk("flush_blocks_ready", {31'b0, op_ready}, 0);
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1 chk("flush_blocks_mtlo", lo, lo_m);
        $display("step flush+op: lo=%h", lo);

        // div_complete in IDLE is ignored
        @(negedge clk);
        div_complete = 1'b1; div_quotient = 32'hAAAA; div_remainder = 32'hBBBB;
        @(negedge clk);
        div_complete = 1'b0;
        #1;
        chk("idle_cmpl_hi", hi, hi_m);
        chk("idle_cmpl_lo", lo, lo_m);
        $display("step idle complete: ignored");

        // 4a: flush in WAIT -> DRAIN, result discarded
        issue(OP_DIV, 32'd50, 32'd7);
        #1 chk("drain_launch_en", {31'b0, div_en}, 1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0; mf_valid = 1'b1; op_valid = 1'b1; op_code = OP_MTLO; op_rs = 32'h5555;
        #1;
        chk("drain_not_ready", {31'b0, op_ready}, 0);
        chk("drain_no_stall", {31'b0, mf_stall}, 0);
        repeat (3) @(negedge clk);
        #1 chk("drain_still_busy", {31'b0, op_ready}, 0);
        op_valid = 1'b0; mf_valid = 1'b0;
        div_complete = 1'b1; div_quotient = 32'h7; div_remainder = 32'h1;
        @(negedge clk); div_complete = 1'b0;
        #1;
        chk("drain_hi", hi, hi_m);
        chk("drain_lo", lo, lo_m);
        chk("drain_ready", {31'b0, op_ready}, 1);
        $display("step flush in WAIT: drained hi=%h lo=%h", hi, lo);

        // 4b: flush in LAUNCH suppresses div_en
        issue(OP_DIVU, 32'd9, 32'd3);
        flush = 1'b1;
        #1;
        chk("launch_flush_en", {31'b0, div_en}, 0);
        chk("launch_flush_ready", {31'b0, op_ready}, 0);
        @(negedge clk); flush = 1'b0;
        #1;
        chk("launch_flush_idle", {31'b0, op_ready}, 1);
        chk("launch_flush_en2", {31'b0, div_en}, 0);
        $display("step flush in LAUNCH: no launch");
        do_div(1'b0, 32'd1000, 32'd7, 3, 1'b0);
        $display("step DIVU after flush: hi=%h lo=%h", hi, lo);

        // flush together with complete in WAIT: result still written
        push_div(1'b1, 32'd40, 32'hFFFF_FFFD);
        issue(OP_DIV, 32'd40, 32'hFFFF_FFFD);
        @(negedge clk);
        e = sb.pop_front();
        flush = 1'b1; div_complete = 1'b1; div_quotient = e.quo; div_remainder = e.rem;
        @(negedge clk);
        flush = 1'b0; div_complete = 1'b0;
        #1;
        chk("flush_cmpl_hi", hi, e.exp_hi);
        chk("flush_cmpl_lo", lo, e.exp_lo);
        chk("flush_cmpl_ready", {31'b0, op_ready}, 1);
        $display("step flush+complete: hi=%h lo=%h", hi, lo);

        // 5: divider never completes -> timeout
        issue(OP_DIV, 32'd77, 32'd5);
        k = 0;
        while (err !== 1'b1 && k < TMO + 12) begin
            @(negedge clk); k++; #1;
        end
        chk("timeout_cycles", k, TMO + 1);
        chk("timeout_err", {31'b0, err}, 1);
        chk("timeout_idle", {31'b0, op_ready}, 1);
        chk("timeout_hi", hi, hi_m);
        do_div(1'b0, 32'd20, 32'd6, 2, 1'b1);
        chk("err_sticky", {31'b0, err}, 1);
        $display("step timeout: err=%0d after %0d cycles", err, k);

        // 6: async reset mid-WAIT
        issue(OP_DIV, 32'd33, 32'd4);
        @(negedge clk); @(negedge clk);
        resetn = 1'b0; mf_valid = 1'b1;
        #1;
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_err", {31'b0, err}, 0);
        chk("arst_ready", {31'b0, op_ready}, 0);
        chk("arst_stall", {31'b0, mf_stall}, 0);
        chk("arst_dividend", div_dividend, 0);
        @(negedge clk); resetn = 1'b1; mf_valid = 1'b0;
        hi_m = '0; lo_m = '0;
        $display("step reset mid-WAIT: cleared");
        do_div(1'b1, 32'hFFFF_FF9C, 32'd9, 5, 1'b0);
        $display("step DIV after reset: hi=%h lo=%h", hi, lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
